// File: rtl/escalonador_avaliacao_pkg.sv
// Shared types, segment patterns and helpers for the evaluation scheduler.
package aval_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Segment order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_Y0 = 7'b0001100;
  localparam logic [6:0] SEG_Y1 = 7'b1111010;
  localparam logic [6:0] SEG_Y2 = 7'b1111100;
  localparam logic [6:0] SEG_Y3 = 7'b1110011;

  function automatic logic [6:0] seg_decode(input logic [1:0] y);
    logic [6:0] s;
    case (y)
      2'b00:   s = SEG_Y0;
      2'b01:   s = SEG_Y1;
      2'b10:   s = SEG_Y2;
      default: s = SEG_Y3;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] i;
    case (oh)
      4'b0010: i = 2'd1;
      4'b0100: i = 2'd2;
      4'b1000: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/escalonador_avaliacao_rr_arbiter4.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 3->0.
module rr_arbiter4
  import aval_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] win,
  output logic       any_req
);

  logic [1:0] idx;

  always_comb begin
    win = '0;
    idx = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + 2'(k);
      if ((win == 4'b0000) && req[idx]) win[idx] = 1'b1;
    end
    any_req = |req;
  end

endmodule

// File: rtl/escalonador_avaliacao.sv
// Round-robin sequencer sharing one external evaluation unit and its display.
// Optional AVAL_BLANK_EN: blank the display on return to IDLE.
module escalonador_avaliacao
  import aval_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [7:0]  req_e,
  input  logic [15:0] req_p,
  output logic [1:0]  eval_e,
  output logic [3:0]  eval_p,
  input  logic [1:0]  eval_y,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [1:0]  result,
  output logic        result_valid,
  output logic [6:0]  seg,
  output logic        busy
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic [1:0]       gidx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       win;
  logic             any_req;
  logic [1:0]       win_idx;
  logic [1:0]       sel_e;
  logic [3:0]       sel_p;

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .any_req (any_req)
  );

  assign win_idx = onehot_idx(win);
  assign sel_e   = req_e[{win_idx, 1'b0} +: 2];
  assign sel_p   = req_p[{win_idx, 2'b00} +: 4];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   state_nxt = SHOW;
      SHOW:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      gidx         <= 2'd0;
      cnt          <= '0;
      grant        <= 4'b0000;
      done         <= 4'b0000;
      eval_e       <= 2'b00;
      eval_p       <= 4'b0000;
      result       <= 2'b00;
      result_valid <= 1'b0;
      seg          <= 7'b0000000;
    end else begin
      state <= state_nxt;
      case (state)
        // Operands are frozen here so later input changes cannot disturb the evaluation
        IDLE: begin
          if (any_req) begin
            eval_e <= sel_e;
            eval_p <= sel_p;
            grant  <= win;
            gidx   <= win_idx;
          end
        end
        GRANT: begin
          result       <= eval_y;
          seg          <= seg_decode(eval_y);
          result_valid <= 1'b1;
          done         <= grant;
          cnt          <= CNT_W'(HOLD_CYCLES - 1);
        end
        SHOW: begin
          done <= 4'b0000;
          if (cnt == '0) begin
            grant        <= 4'b0000;
            result_valid <= 1'b0;
            ptr          <= gidx + 2'd1;
`ifdef AVAL_BLANK_EN
            seg          <= 7'b0000000;
`else
            seg          <= seg;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_avaliacao.sv
// Scoreboard bench for escalonador_avaliacao with a behavioural evaluation unit.
module tb_escalonador_avaliacao;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_e;
  logic [15:0] req_p;
  logic [1:0]  eval_e;
  logic [3:0]  eval_p;
  logic [1:0]  eval_y;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [1:0]  result;
  logic        result_valid;
  logic [6:0]  seg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] y;
    logic [6:0] s;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  // Evaluation unit model: class = mode XOR low pattern bits
  assign eval_y = eval_e ^ eval_p[1:0];

  escalonador_avaliacao #(.HOLD_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_e        (req_e),
    .req_p        (req_p),
    .eval_e       (eval_e),
    .eval_p       (eval_p),
    .eval_y       (eval_y),
    .grant        (grant),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .seg          (seg),
    .busy         (busy)
  );

  function automatic logic [6:0] exp_seg(input logic [1:0] y);
    logic [6:0] s;
    case (y)
      2'b00:   s = 7'b0001100;
      2'b01:   s = 7'b1111010;
      2'b10:   s = 7'b1111100;
      default: s = 7'b1110011;
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] y);
    exp_t e;
    e.g = g; e.y = y; e.s = exp_seg(y);
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input string name, input logic [3:0] g);
    int n = 0;
    while (grant == 4'b0000 && n < 30) begin
      @(negedge clk); n++;
    end
    check(name, grant, g);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk); n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, grant, 4'b0000);
    check({tag, "_done"}, done, 4'b0000);
    check({tag, "_eval_e"}, eval_e, 2'b00);
    check({tag, "_eval_p"}, eval_p, 4'b0000);
    check({tag, "_result"}, result, 2'b00);
    check({tag, "_rvalid"}, result_valid, 1'b0);
    check({tag, "_seg"}, seg, 7'b0000000);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done !== 4'b0000) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got %0h expected none", done);
        end else begin
          e = sbq.pop_front();
          check("sb_done", done, e.g);
          check("sb_grant", grant, e.g);
          check("sb_result", result, e.y);
          check("sb_seg", seg, e.s);
          check("sb_rvalid", result_valid, 1'b1);
        end
      end
    end
  end

  initial begin
    int rv_cnt;
    int k;
    int cyc;
    int t[5];
    logic [3:0] prev_g;
    logic regrant;

    rst_n = 1'b0; req = '0; req_e = '0; req_p = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request, exact latency and SHOW length
    req = 4'b0001; req_e[1:0] = 2'b01; req_p[3:0] = 4'b1000;
    push(4'b0001, 2'b01);
    @(negedge clk);
    check("t1_grant_latency", grant, 4'b0001);
    check("t1_eval_e", eval_e, 2'b01);
    check("t1_eval_p", eval_p, 4'b1000);
    req = 4'b0000;
    rv_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
    end
    check("t1_rvalid_cycles", rv_cnt, 4);
    check("t1_idle", busy, 1'b0);
    check("t1_result_hold", result, 2'b01);
`ifdef AVAL_BLANK_EN
    check("t1_seg_after", seg, 7'b0000000);
`else
    check("t1_seg_after", seg, 7'b1111010);
`endif

    // Every class through requester 1
    for (int y = 0; y < 4; y++) begin
      req_e[3:2] = 2'b00;
      req_p[7:4] = {2'b10, 2'(y)};
      req = 4'b0010;
      push(4'b0010, 2'(y));
      @(negedge clk);
      wait_grant("cls_grant", 4'b0010);
      req = 4'b0000;
      wait_idle("cls_idle");
    end

    // All four held: strict rotation and fixed spacing
    do_reset();
    req_e = {2'd3, 2'd2, 2'd1, 2'd0};
    req_p = 16'h0000;
    req   = 4'b1111;
    push(4'b0001, 2'd0); push(4'b0010, 2'd1); push(4'b0100, 2'd2);
    push(4'b1000, 2'd3); push(4'b0001, 2'd0);
    k = 0; cyc = 0; prev_g = 4'b0000;
    while (k < 5 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (grant != 4'b0000 && prev_g == 4'b0000) begin
        t[k] = cyc; k++;
      end
      prev_g = grant;
    end
    req = 4'b0000;
    check("rr_grant_count", k, 5);
    for (int i = 0; i < 4; i++) check("rr_spacing", t[i+1] - t[i], 6);
    wait_idle("rr_idle");

    // Operand change and request drop while in flight
    req_e[5:4] = 2'b10; req_p[11:8] = 4'b0001;
    req = 4'b0100;
    push(4'b0100, 2'b11);
    @(negedge clk);
    wait_grant("chg_grant", 4'b0100);
    req_e[5:4] = 2'b01; req_p[11:8] = 4'b1111;
    @(negedge clk);
    req = 4'b0000;
    wait_idle("chg_idle");
    regrant = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (grant != 4'b0000) regrant = 1'b1;
    end
    check("chg_no_regrant", regrant, 1'b0);

    // Asynchronous reset in the middle of SHOW
    req_e[7:6] = 2'b11; req_p[15:12] = 4'b0001;
    req = 4'b1000;
    push(4'b1000, 2'b10);
    @(negedge clk);
    wait_grant("ar_grant", 4'b1000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    req = 4'b0000;
    #1 check_reset_vals("ar");
    @(negedge clk);
    rst_n = 1'b1;
    req_e[1:0] = 2'b10; req_p[3:0] = 4'b0000;
    req = 4'b1001;
    push(4'b0001, 2'b10);
    @(negedge clk);
    check("ar_next_grant", grant, 4'b0001);
    req = 4'b0000;
    wait_idle("ar_idle");

    repeat (3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
